shift_op_sequencer: RTL
=======================

SHIFT_OP_SEQUENCER -- requirements
Module: shift_op_sequencer

Interface
REQ-001 Parameter: CNT_W, 3, width of shift-count field; max shifts per command = 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  00 LOAD, 01 SHR (serial fill), 10 SHL (serial fill), 11 ROR (rotate right).
REQ-007 cmd_count  input  CNT_W  number of shift cycles.
REQ-008 cmd_data  input  4  value parallel-loaded before shifting.
REQ-009 serial_in  input  1  fill bit for SHR/SHL.
REQ-010 sh_q  input  4  shifter register output (feedback).
REQ-011 sh_mode  output  2  shifter mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-012 sh_sr / sh_sl  output  1 each  shifter right-/left-serial inputs.
REQ-013 sh_in  output  4  shifter parallel data.
REQ-014 result  output  4  registered shifter value at command completion.
REQ-015 done  output  1  one-cycle completion pulse; result valid while high.

Function
REQ-016 FSM states IDLE, LOAD, SHIFT, CAPTURE; cmd_ready SHALL equal (state==IDLE).
REQ-017 Handshake: accept on rising edge with cmd_valid&cmd_ready; latch op, count, data; IDLE->LOAD; cmd_* ignored until next IDLE.
REQ-018 LOAD (1 cycle): sh_mode=11, sh_in=latched data; next SHIFT if op!=00 and count!=0, else CAPTURE.
REQ-019 SHIFT: remaining counter loaded with count at LOAD exit, decremented each SHIFT cycle; SHIFT->CAPTURE on edge where remaining==1.
REQ-020 SHIFT drive: SHR sh_mode=01, sh_sr=serial_in; SHL sh_mode=10, sh_sl=serial_in; ROR sh_mode=01, sh_sr=sh_q[0].
REQ-021 CAPTURE (1 cycle): sh_mode=00; on exit edge result<=sh_q, done<=1, state->IDLE.
REQ-022 done SHALL be high exactly the first IDLE cycle after CAPTURE, otherwise low.
REQ-023 Latency: accept at edge E0 -> done high in cycle following edge E0+count+2 (count treated as 0 for LOAD).
REQ-024 Back-to-back: command presented during the done cycle SHALL be accepted; result holds until next CAPTURE exit.
REQ-025 Outside LOAD/SHIFT: sh_mode=00, sh_sr=0, sh_sl=0, sh_in=0; sh_sr/sh_sl=0 whenever not selected in REQ-020.
REQ-026 count at max (2^CNT_W-1) SHALL execute exactly that many shifts; no wrap of remaining.

Reset
REQ-027 reset low SHALL immediately force state IDLE, remaining=0, result=0, done=0, and all sh_* outputs to 0.
REQ-028 Reset mid-operation SHALL abandon the command with no done pulse; first accept possible on first rising edge after reset deasserts.

Configuration
REQ-029 Macro SHIFT_SEQ_ABORT_EN: when defined, adds input abort (1 bit); abort high at a rising edge in LOAD/SHIFT/CAPTURE SHALL return to IDLE, no done, result unchanged; abort ignored in IDLE.
REQ-030 Without SHIFT_SEQ_ABORT_EN, the abort port SHALL not exist and commands always run to completion.

Verification
REQ-031 LOAD op=00, data=0111, count=5 -> sh_mode=11 one cycle, no shifts, done 2 cycles after accept, result=0111.
REQ-032 SHR data=1011, count=2, serial_in=0 -> two sh_mode=01 cycles, result=0010, done 4 cycles after accept.
REQ-033 SHL data=0111, count=1, serial_in=1 -> result=1111; ROR data=0001, count=3 -> result=0010.
REQ-034 Back-to-back: second command held valid during done -> accepted that cycle, cmd_ready low next cycle, both results correct.
REQ-035 reset low mid-SHIFT of SHR count=7 -> state IDLE, result=0, done never pulses, sh_mode=00 immediately.
REQ-036 With SHIFT_SEQ_ABORT_EN: abort during SHIFT of prior-result=0101 command -> IDLE next cycle, no done, result stays 0101.

Source files
------------

// File: rtl/shift_op_sequencer.sv
// shift_op_sequencer: drives an external 4-bit shifter through LOAD/SHIFT/CAPTURE for one command at a time.
// Optional abort input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_op_sequencer #(
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   input  logic [3:0]       cmd_data_i,
   input  logic             serial_in_i,
   input  logic [3:0]       sh_q_i,
   output logic [1:0]       sh_mode_o,
   output logic             sh_sr_o,
   output logic             sh_sl_o,
   output logic [3:0]       sh_in_o,
   output logic [3:0]       result_o,
   output logic             done_o
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_e;
   localparam logic [1:0] OP_LOAD = 2'b00, OP_SHR = 2'b01, OP_SHL = 2'b10, OP_ROR = 2'b11;
   state_e state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, rem_q, rem_d;
   logic [3:0] data_q, data_d, result_q, result_d;
   logic done_q, done_d;
   logic abort;
`ifdef SHIFT_SEQ_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif
   assign cmd_ready_o = (state_q == IDLE);
   assign result_o = result_q;
   assign done_o = done_q;
   // State and command registers, all cleared by the asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         data_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         data_q   <= data_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end
   // Next state: accept in IDLE, load once, shift count times, capture, with abort overriding any busy state
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      data_d   = data_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            state_d = LOAD;
            op_d    = cmd_op_i;
            cnt_d   = cmd_count_i;
            data_d  = cmd_data_i;
         end
         LOAD: begin
            state_d = (op_q != OP_LOAD && cnt_q != '0) ? SHIFT : CAPTURE;
            rem_d   = cnt_q;
         end
         SHIFT: begin
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? CAPTURE : SHIFT;
         end
         CAPTURE: begin
            state_d  = IDLE;
            result_d = sh_q_i;
            done_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d  = IDLE;
         rem_d    = '0;
         result_d = result_q;
         done_d   = 1'b0;
      end
   end
   // Shifter controls: parallel load in LOAD, op-dependent direction and fill in SHIFT, hold elsewhere
   always_comb begin
      sh_mode_o = 2'b00;
      sh_sr_o   = 1'b0;
      sh_sl_o   = 1'b0;
      sh_in_o   = 4'b0000;
      if (state_q == LOAD) begin
         sh_mode_o = 2'b11;
         sh_in_o   = data_q;
      end else if (state_q == SHIFT) begin
         sh_mode_o = (op_q == OP_SHL) ? 2'b10 : 2'b01;
         sh_sr_o   = (op_q == OP_SHR) ? serial_in_i : (op_q == OP_ROR) ? sh_q_i[0] : 1'b0;
         sh_sl_o   = (op_q == OP_SHL) ? serial_in_i : 1'b0;
      end
   end
endmodule
